// File: rtl/mem_rsp_delay_shim.sv
// Response delay shim between TL-UL SRAM adapters and 1-cycle SRAM models.
// Each channel queues accepted requests and releases responses in order after a per-request latency.
module mem_rsp_delay_shim #(
  parameter int unsigned NumChan        = 2,
  parameter int unsigned DataW          = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned MaxLatency     = 8,
  parameter bit          WriteAck       = 1'b0,
  localparam int unsigned LatW          = $clog2(MaxLatency + 1),
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumChan-1:0]             up_req_i,
  input  logic [NumChan-1:0]             up_we_i,
  output logic [NumChan-1:0]             up_gnt_o,
  output logic [NumChan-1:0]             up_rvalid_o,
  output logic [NumChan-1:0][DataW-1:0]  up_rdata_o,
  output logic [NumChan-1:0]             dn_req_o,
  input  logic [NumChan-1:0]             dn_gnt_i,
  input  logic [NumChan-1:0][DataW-1:0]  dn_rdata_i,
  input  logic [NumChan-1:0][LatW-1:0]   lat_i,
  output logic [NumChan-1:0][CntW-1:0]   outstanding_o,
  output logic [NumChan-1:0]             full_o
);

  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int          Depth = int'(MaxOutstanding);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    logic [PtrW-1:0] nxt;
    if (ptr == PtrW'(MaxOutstanding - 1)) begin
      nxt = '0;
    end else begin
      nxt = ptr + PtrW'(1);
    end
    return nxt;
  endfunction

  function automatic logic [LatW-1:0] lat_clamp(input logic [LatW-1:0] lat);
    logic [LatW-1:0] eff;
    if (lat == '0) begin
      eff = LatW'(1);
    end else if (lat > LatW'(MaxLatency)) begin
      eff = LatW'(MaxLatency);
    end else begin
      eff = lat;
    end
    return eff;
  endfunction

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    logic [MaxOutstanding-1:0] we_q, we_d, dv_q, dv_d;
    logic [LatW-1:0]           rem_q  [MaxOutstanding];
    logic [LatW-1:0]           rem_d  [MaxOutstanding];
    logic [DataW-1:0]          data_q [MaxOutstanding];
    logic [DataW-1:0]          data_d [MaxOutstanding];
    logic [PtrW-1:0]           rptr_q, rptr_d, wptr_q, wptr_d, cap_idx_q, cap_idx_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      full_q, full_d, cap_q, cap_d;
    logic                      full, accept, head_due, rvalid;
    logic [DataW-1:0]          rdata;

    // Handshake and in-order response selection; a latency-1 head bypasses the capture flop.
    always_comb begin
      full     = (cnt_q == CntW'(MaxOutstanding));
      accept   = up_req_i[c] & dn_gnt_i[c] & ~full & ~rst_i;
      head_due = (cnt_q != '0) & (rem_q[rptr_q] <= LatW'(1));
      rvalid   = head_due & (~we_q[rptr_q] | WriteAck) & ~rst_i;
      if (rvalid && !we_q[rptr_q]) begin
        rdata = dv_q[rptr_q] ? data_q[rptr_q] : dn_rdata_i[c];
      end else begin
        rdata = '0;
      end
    end

    assign dn_req_o[c]      = up_req_i[c] & ~full & ~rst_i;
    assign up_gnt_o[c]      = dn_gnt_i[c] & ~full & ~rst_i;
    assign up_rvalid_o[c]   = rvalid;
    assign up_rdata_o[c]    = rdata;
    assign outstanding_o[c] = cnt_q;
    assign full_o[c]        = full_q;

    // Queue update: age entries, capture read data, pop the due head, push the accepted request.
    always_comb begin
      we_d      = we_q;
      dv_d      = dv_q;
      rem_d     = rem_q;
      data_d    = data_q;
      rptr_d    = rptr_q;
      wptr_d    = wptr_q;
      cap_d     = 1'b0;
      cap_idx_d = cap_idx_q;
      for (int i = 0; i < Depth; i++) begin
        if (rem_q[i] != '0) begin
          rem_d[i] = rem_q[i] - LatW'(1);
        end else begin
          rem_d[i] = rem_q[i];
        end
      end
      if (cap_q) begin
        data_d[cap_idx_q] = dn_rdata_i[c];
        dv_d[cap_idx_q]   = 1'b1;
      end else begin
        dv_d = dv_d;
      end
      if (head_due) begin
        rptr_d = ptr_inc(rptr_q);
      end else begin
        rptr_d = rptr_q;
      end
      if (accept) begin
        we_d[wptr_q]   = up_we_i[c];
        dv_d[wptr_q]   = 1'b0;
        data_d[wptr_q] = '0;
        rem_d[wptr_q]  = lat_clamp(lat_i[c]);
        cap_d          = ~up_we_i[c];
        cap_idx_d      = wptr_q;
        wptr_d         = ptr_inc(wptr_q);
      end else begin
        wptr_d = wptr_q;
      end
      case ({accept, head_due})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
      full_d = (cnt_d == CntW'(MaxOutstanding));
    end

    // State registers with synchronous reset; reset drops every pending response.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        we_q      <= '0;
        dv_q      <= '0;
        rptr_q    <= '0;
        wptr_q    <= '0;
        cap_idx_q <= '0;
        cnt_q     <= '0;
        full_q    <= 1'b0;
        cap_q     <= 1'b0;
        for (int i = 0; i < Depth; i++) begin
          rem_q[i]  <= '0;
          data_q[i] <= '0;
        end
      end else begin
        we_q      <= we_d;
        dv_q      <= dv_d;
        rptr_q    <= rptr_d;
        wptr_q    <= wptr_d;
        cap_idx_q <= cap_idx_d;
        cnt_q     <= cnt_d;
        full_q    <= full_d;
        cap_q     <= cap_d;
        rem_q     <= rem_d;
        data_q    <= data_d;
      end
    end
  end

endmodule

// File: tb/tb_mem_rsp_delay_shim.sv
// Bench for mem_rsp_delay_shim: three instances (depth 4 with write acks, depth 3, depth 1)
// share one stimulus stream and are checked against a response-schedule model every cycle.
module tb_mem_rsp_delay_shim;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       up_req, up_we, dn_gnt;
  logic [1:0][31:0] dn_rdata;
  logic [1:0][3:0]  lat;

  logic [1:0]       gnt    [3];
  logic [1:0]       rvalid [3];
  logic [1:0][31:0] rdata  [3];
  logic [1:0]       dreq   [3];
  logic [1:0][2:0]  outs   [3];
  logic [1:0]       full   [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned MOg = (g == 0) ? 4 : ((g == 1) ? 3 : 1);
    localparam bit          WAg = (g == 0);
    localparam int          CW  = $clog2(MOg + 1);
    logic [1:0][CW-1:0] outs_l;
    mem_rsp_delay_shim #(
      .NumChan(2), .DataW(32), .MaxOutstanding(MOg), .MaxLatency(8), .WriteAck(WAg)
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .up_req_i(up_req), .up_we_i(up_we), .up_gnt_o(gnt[g]),
      .up_rvalid_o(rvalid[g]), .up_rdata_o(rdata[g]),
      .dn_req_o(dreq[g]), .dn_gnt_i(dn_gnt), .dn_rdata_i(dn_rdata),
      .lat_i(lat), .outstanding_o(outs_l), .full_o(full[g])
    );
    assign outs[g][0] = 3'(outs_l[0]);
    assign outs[g][1] = 3'(outs_l[1]);
  end

  function automatic int mo_of(input int i);
    case (i)
      0:       return 4;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input int i, input int c,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d ch%0d cyc=%0d: got %h expected %h", name, i, c, cyc, got, exp);
    end
  endtask

  // Model: each accepted request is scheduled at max(accept+L, previous response+1).
  typedef struct {
    int acc;
    int resp;
    bit we;
  } ent_t;

  ent_t        mq [6][$];
  int          lr [6];
  logic [31:0] hist [2][1024];
  logic        rst_prev = 1'b0;

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) hist[c][cyc % 1024] = dn_rdata[c];
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 2; c++) begin
        int k, occ, L, r;
        bit isfull, due, ev;
        logic [31:0] ed;
        ent_t e;
        k = i * 2 + c;
        if (rst) begin
          chk("rst_gnt", i, c, 32'(gnt[i][c]), 32'd0);
          chk("rst_rvalid", i, c, 32'(rvalid[i][c]), 32'd0);
          chk("rst_rdata", i, c, rdata[i][c], 32'd0);
          chk("rst_dnreq", i, c, 32'(dreq[i][c]), 32'd0);
          if (rst_prev) begin
            chk("rst_outst", i, c, 32'(outs[i][c]), 32'd0);
            chk("rst_full", i, c, 32'(full[i][c]), 32'd0);
          end
          mq[k].delete();
          lr[k] = -1;
        end else begin
          occ    = mq[k].size();
          isfull = (occ == mo_of(i));
          due    = 1'b0;
          ev     = 1'b0;
          ed     = 32'd0;
          if (occ > 0) begin
            if (mq[k][0].resp == cyc) begin
              due = 1'b1;
              if (!mq[k][0].we) begin
                ev = 1'b1;
                ed = hist[c][(mq[k][0].acc + 1) % 1024];
              end else begin
                ev = (i == 0);
              end
            end
          end
          chk("rvalid", i, c, 32'(rvalid[i][c]), 32'(ev));
          chk("rdata", i, c, rdata[i][c], ed);
          chk("gnt", i, c, 32'(gnt[i][c]), 32'(dn_gnt[c] & ~isfull));
          chk("dn_req", i, c, 32'(dreq[i][c]), 32'(up_req[c] & ~isfull));
          chk("outstanding", i, c, 32'(outs[i][c]), 32'(occ));
          chk("full", i, c, 32'(full[i][c]), 32'(isfull));
          if (due) void'(mq[k].pop_front());
          if (up_req[c] && dn_gnt[c] && !isfull) begin
            L = int'(lat[c]);
            if (L < 1) L = 1;
            if (L > 8) L = 8;
            r = cyc + L;
            if (r < lr[k] + 1) r = lr[k] + 1;
            e.acc  = cyc;
            e.resp = r;
            e.we   = up_we[c];
            mq[k].push_back(e);
            lr[k] = r;
          end
        end
      end
    end
    rst_prev = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    up_req = 2'b00;
    up_we  = 2'b00;
    dn_gnt = 2'b11;
    lat    = {4'd1, 4'd1};
    for (int c = 0; c < 2; c++) dn_rdata[c] = {8'h5A, 8'(c), 16'(cyc)};
  endtask

  initial begin
    int nrv;
    rst      = 1'b1;
    up_req   = 2'b00;
    up_we    = 2'b00;
    dn_gnt   = 2'b11;
    lat      = {4'd1, 4'd1};
    dn_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();

    // Baseline read, latency 1; depth-1 instance must block the follow-up request.
    tick(); up_req[0] = 1'b1;
    tick(); up_req[0] = 1'b1; dn_rdata[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("base_rv", 0, 0, 32'(rvalid[0][0]), 32'd1);
    chk("base_rd", 0, 0, rdata[0][0], 32'hDEADBEEF);
    chk("base_rd1", 2, 0, rdata[2][0], 32'hDEADBEEF);
    chk("base_blk", 2, 0, 32'(gnt[2][0]), 32'd0);
    tick();
    @(negedge clk);
    chk("base_once", 2, 0, 32'(rvalid[2][0]), 32'd0);
    repeat (5) tick();

    // In-order responses with head-of-line blocking on ch1.
    tick(); up_req[1] = 1'b1; lat[1] = 4'd5;
    tick(); up_req[1] = 1'b1; lat[1] = 4'd1; dn_rdata[1] = 32'hA;
    tick(); dn_rdata[1] = 32'hB;
    @(negedge clk);
    chk("hol_t2", 0, 1, 32'(rvalid[0][1]), 32'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("hol_t5_rv", 0, 1, 32'(rvalid[0][1]), 32'd1);
    chk("hol_t5_rd", 0, 1, rdata[0][1], 32'hA);
    tick();
    @(negedge clk);
    chk("hol_t6_rv", 0, 1, 32'(rvalid[0][1]), 32'd1);
    chk("hol_t6_rd", 0, 1, rdata[0][1], 32'hB);
    repeat (6) tick();

    // Full queue on ch0 while ch1 keeps flowing.
    for (int rel = 0; rel < 14; rel++) begin
      tick();
      up_req[0] = 1'b1; lat[0] = 4'd8;
      if (rel % 2 == 0) begin up_req[1] = 1'b1; lat[1] = 4'd2; end
      @(negedge clk);
      if (rel == 3) chk("full_t3_gnt", 0, 0, 32'(gnt[0][0]), 32'd1);
      if (rel == 4) begin
        chk("full_t4_full", 0, 0, 32'(full[0][0]), 32'd1);
        chk("full_t4_gnt", 0, 0, 32'(gnt[0][0]), 32'd0);
        chk("full_t4_req", 0, 0, 32'(dreq[0][0]), 32'd0);
        chk("iso_t4_gnt", 0, 1, 32'(gnt[0][1]), 32'd1);
      end
      if (rel == 8) begin
        chk("full_t8_rv", 0, 0, 32'(rvalid[0][0]), 32'd1);
        chk("full_t8_gnt", 0, 0, 32'(gnt[0][0]), 32'd0);
      end
      if (rel == 9) chk("full_t9_gnt", 0, 0, 32'(gnt[0][0]), 32'd1);
    end
    repeat (40) tick();

    // Write with latency 3: ack only on the WriteAck instance, slot freed either way.
    tick(); up_req[0] = 1'b1; up_we[0] = 1'b1; lat[0] = 4'd3;
    repeat (3) tick();
    @(negedge clk);
    chk("wr_ack_rv", 0, 0, 32'(rvalid[0][0]), 32'd1);
    chk("wr_ack_rd", 0, 0, rdata[0][0], 32'd0);
    chk("wr_noack_rv", 1, 0, 32'(rvalid[1][0]), 32'd0);
    chk("wr_noack_os3", 1, 0, 32'(outs[1][0]), 32'd1);
    tick();
    @(negedge clk);
    chk("wr_noack_os4", 1, 0, 32'(outs[1][0]), 32'd0);
    repeat (5) tick();

    // Latency clamping and pointer wrap on ch1.
    for (int rel = 0; rel < 10; rel++) begin
      tick(); up_req[1] = 1'b1; lat[1] = 4'd0;
      @(negedge clk);
      if (rel == 1) begin
        chk("clamp0_rv", 1, 1, 32'(rvalid[1][1]), 32'd1);
        chk("clamp0_rd", 1, 1, rdata[1][1], dn_rdata[1]);
      end
    end
    repeat (5) tick();
    for (int rel = 0; rel < 20; rel++) begin
      tick(); up_req[1] = 1'b1; lat[1] = 4'd15;
      @(negedge clk);
      if (rel == 7) chk("clamp15_t7", 0, 1, 32'(rvalid[0][1]), 32'd0);
      if (rel == 8) chk("clamp15_t8", 0, 1, 32'(rvalid[0][1]), 32'd1);
    end
    repeat (60) tick();

    // Reset mid-flight with ch0 reads pending and ch1 traffic alongside.
    for (int rel = 0; rel < 4; rel++) begin
      tick();
      up_req[1] = 1'b1; lat[1] = 4'd2;
      if (rel < 3) begin up_req[0] = 1'b1; lat[0] = 4'd8; end
    end
    tick(); rst = 1'b1;
    tick();
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_os", 0, 0, 32'(outs[0][0]), 32'd0);
    nrv = 0;
    for (int n = 0; n < 15; n++) begin
      tick();
      @(negedge clk);
      if (rvalid[0][0] || rvalid[1][0] || rvalid[2][0]) nrv++;
    end
    chk("rst_mid_norv", 0, 0, 32'(nrv), 32'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
